// File: rtl/id_ex_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_pkg
// Shared definitions for the ID/EX pipeline register.
//   - CTRL_W and the bit positions of each field inside the packed control
//     bundle carried from decode to EX/MEM/WB.
//   - ALU_OP encodings shared by the decoder and the ALU control unit.
// Control bundle layout (MSB .. LSB):
//   [9] reg_write [8] mem_read [7] mem_write [6] mem_to_reg [5] branch
//   [4] alu_src   [3] reg_dst  [2:0] alu_op
// -----------------------------------------------------------------------------
package id_ex_pkg;

   localparam int CTRL_W          = 10;

   localparam int CTRL_REG_WRITE  = 9;
   localparam int CTRL_MEM_READ   = 8;
   localparam int CTRL_MEM_WRITE  = 7;
   localparam int CTRL_MEM_TO_REG = 6;
   localparam int CTRL_BRANCH     = 5;
   localparam int CTRL_ALU_SRC    = 4;
   localparam int CTRL_REG_DST    = 3;
   localparam int CTRL_ALU_OP_MSB = 2;
   localparam int CTRL_ALU_OP_LSB = 0;

   localparam int REG_IDX_W       = 5;

   typedef enum logic [2:0] {
      ALU_OP_ADD   = 3'd0,   // loads/stores/addi
      ALU_OP_SUB   = 3'd1,   // beq/bne compare
      ALU_OP_RTYPE = 3'd2,   // decode funct field
      ALU_OP_AND   = 3'd3,   // andi
      ALU_OP_OR    = 3'd4,   // ori
      ALU_OP_XOR   = 3'd5,   // xori
      ALU_OP_SLT   = 3'd6,   // slti
      ALU_OP_LUI   = 3'd7    // lui
   } alu_op_e;

endpackage

// File: rtl/id_ex_reg_if.sv
// -----------------------------------------------------------------------------
// id_ex_reg_if
// Bundle of all ID-side inputs and EX-side outputs of the ID/EX register.
// Signal suffixes are relative to the pipeline register itself:
//   *_i : driven by the ID stage / hazard control (hold, flush)
//   *_o : registered EX-stage copies plus stall_o and bubble_cnt_o
// Modports:
//   slave  : the pipeline register (id_ex_reg)
//   master : the surrounding datapath (drives *_i, observes *_o)
// -----------------------------------------------------------------------------
interface id_ex_reg_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 10,
   parameter int CNT_W  = 16
);
   logic              hold_i;
   logic              flush_i;
   logic              valid_i;
   logic [CTRL_W-1:0] ctrl_i;
   logic [DATA_W-1:0] pc4_i;
   logic [DATA_W-1:0] rs_data_i;
   logic [DATA_W-1:0] rt_data_i;
   logic [DATA_W-1:0] imm_i;
   logic [4:0]        rs_i;
   logic [4:0]        rt_i;
   logic [4:0]        rd_i;
   logic              zext_i;

   logic              valid_o;
   logic [CTRL_W-1:0] ctrl_o;
   logic [DATA_W-1:0] pc4_o;
   logic [DATA_W-1:0] rs_data_o;
   logic [DATA_W-1:0] rt_data_o;
   logic [DATA_W-1:0] imm_o;
   logic [4:0]        rs_o;
   logic [4:0]        rt_o;
   logic [4:0]        rd_o;
   logic              stall_o;
   logic [CNT_W-1:0]  bubble_cnt_o;

   modport slave (
      input  hold_i, flush_i, valid_i, ctrl_i, pc4_i, rs_data_i, rt_data_i,
             imm_i, rs_i, rt_i, rd_i, zext_i,
      output valid_o, ctrl_o, pc4_o, rs_data_o, rt_data_o, imm_o, rs_o, rt_o,
             rd_o, stall_o, bubble_cnt_o
   );

   modport master (
      output hold_i, flush_i, valid_i, ctrl_i, pc4_i, rs_data_i, rt_data_i,
             imm_i, rs_i, rt_i, rd_i, zext_i,
      input  valid_o, ctrl_o, pc4_o, rs_data_o, rt_data_o, imm_o, rs_o, rt_o,
             rd_o, stall_o, bubble_cnt_o
   );
endinterface

// File: rtl/id_ex_reg_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use detector. A load sitting in EX whose
// destination (rt) is a source of the valid instruction in ID forces a bubble.
// Register $0 is hard-wired to zero, so it can never create a dependency.
// Ports:
//   valid_ex_i    : EX entry is valid
//   mem_read_ex_i : EX entry is a load
//   rt_ex_i       : EX entry destination register (load target)
//   valid_id_i    : ID instruction is valid
//   rs_id_i/rt_id_i : ID source register indices
//   load_use_o    : hazard present this cycle
// -----------------------------------------------------------------------------
module hazard_detect
   import id_ex_pkg::*;
(
   input  logic                 valid_ex_i,
   input  logic                 mem_read_ex_i,
   input  logic [REG_IDX_W-1:0] rt_ex_i,
   input  logic                 valid_id_i,
   input  logic [REG_IDX_W-1:0] rs_id_i,
   input  logic [REG_IDX_W-1:0] rt_id_i,
   output logic                 load_use_o
);
   logic rt_nonzero;
   logic src_match;

   assign rt_nonzero = (rt_ex_i != '0);
   assign src_match  = (rt_ex_i == rs_id_i) || (rt_ex_i == rt_id_i);
   assign load_use_o = valid_ex_i & mem_read_ex_i & rt_nonzero & valid_id_i & src_match;
endmodule

// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// downstream hold.
// Ports:
//   clk_i  : clock, rising-edge
//   rst_i  : asynchronous active-low reset, clears every register
//   bus    : id_ex_reg_if.slave -- ID-side inputs, EX-side registered outputs,
//            stall_o (freeze PC and IF/ID) and bubble_cnt_o (saturating)
// Edge priority: hold > flush > load-use bubble > normal load.
// Optional build macro IMM_ZEXT_EN: registers zext_i with the control bits and
// zero-extends the upper immediate half on load (andi/ori/xori).
// -----------------------------------------------------------------------------
module id_ex_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 10,
   parameter int CNT_W  = 16
) (
   input logic      clk_i,
   input logic      rst_i,
   id_ex_reg_if.slave bus
);
   import id_ex_pkg::*;

   logic              valid_q,   valid_d;
   logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
   logic [DATA_W-1:0] pc4_q,     pc4_d;
   logic [DATA_W-1:0] rs_data_q, rs_data_d;
   logic [DATA_W-1:0] rt_data_q, rt_data_d;
   logic [DATA_W-1:0] imm_q,     imm_d;
   logic [4:0]        rs_q,      rs_d;
   logic [4:0]        rt_q,      rt_d;
   logic [4:0]        rd_q,      rd_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;
   logic              zext_q,    zext_d;

   logic              load_use;
   logic [DATA_W-1:0] imm_load;

   hazard_detect u_hazard (
      .valid_ex_i    (valid_q),
      .mem_read_ex_i (ctrl_q[CTRL_MEM_READ]),
      .rt_ex_i       (rt_q),
      .valid_id_i    (bus.valid_i),
      .rs_id_i       (bus.rs_i),
      .rt_id_i       (bus.rt_i),
      .load_use_o    (load_use)
   );

   // A flush kills the ID instruction anyway, so it must not also stall fetch.
   assign bus.stall_o = bus.hold_i | (load_use & ~bus.flush_i);

   // Immediate as it will be captured on a load edge.
   always_comb begin
      imm_load = bus.imm_i;
`ifdef IMM_ZEXT_EN
      if (bus.zext_i) begin
         imm_load[DATA_W-1:16] = '0;
      end
`endif
   end

   always_comb begin
      valid_d   = valid_q;
      ctrl_d    = ctrl_q;
      pc4_d     = pc4_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      imm_d     = imm_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      rd_d      = rd_q;
      cnt_d     = cnt_q;
      zext_d    = zext_q;

      if (bus.hold_i) begin
         // everything keeps its value, including the counter
      end else if (bus.flush_i) begin
         // Datapath fields load normally; with no valid/ctrl they are inert.
         valid_d   = 1'b0;
         ctrl_d    = '0;
         zext_d    = 1'b0;
         pc4_d     = bus.pc4_i;
         rs_data_d = bus.rs_data_i;
         rt_data_d = bus.rt_data_i;
         imm_d     = imm_load;
         rs_d      = bus.rs_i;
         rt_d      = bus.rt_i;
         rd_d      = bus.rd_i;
      end else if (load_use) begin
         // Bubble: the dependent instruction stays in ID and re-presents.
         valid_d = 1'b0;
         ctrl_d  = '0;
         zext_d  = 1'b0;
         if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         valid_d   = bus.valid_i;
         // Invalid entries carry no control so later stages never write.
         ctrl_d    = bus.valid_i ? bus.ctrl_i : '0;
         zext_d    = bus.valid_i & bus.zext_i;
         pc4_d     = bus.pc4_i;
         rs_data_d = bus.rs_data_i;
         rt_data_d = bus.rt_data_i;
         imm_d     = imm_load;
         rs_d      = bus.rs_i;
         rt_d      = bus.rt_i;
         rd_d      = bus.rd_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q   <= 1'b0;
         ctrl_q    <= '0;
         pc4_q     <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
         cnt_q     <= '0;
         zext_q    <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         ctrl_q    <= ctrl_d;
         pc4_q     <= pc4_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         rd_q      <= rd_d;
         cnt_q     <= cnt_d;
         zext_q    <= zext_d;
      end
   end

   // zext only shapes the captured immediate; the registered flag and, in the
   // default build, the input itself have no further consumer here.
   logic unused_zext;
`ifdef IMM_ZEXT_EN
   assign unused_zext = zext_q;
`else
   assign unused_zext = zext_q ^ bus.zext_i;
`endif

   assign bus.valid_o      = valid_q;
   assign bus.ctrl_o       = ctrl_q;
   assign bus.pc4_o        = pc4_q;
   assign bus.rs_data_o    = rs_data_q;
   assign bus.rt_data_o    = rt_data_q;
   assign bus.imm_o        = imm_q;
   assign bus.rs_o         = rs_q;
   assign bus.rt_o         = rt_q;
   assign bus.rd_o         = rd_q;
   assign bus.bubble_cnt_o = cnt_q;
endmodule

// File: tb/tb_id_ex_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_reg
// Directed, table-driven bench for id_ex_reg. The counter is instantiated
// 2 bits wide so saturation is reachable in a few load-use pairs.
// -----------------------------------------------------------------------------
module tb_id_ex_reg;
   localparam int CNT_W = 2;

   localparam logic [9:0] C_ADD = 10'h20A;   // reg_write, reg_dst, alu_op=RTYPE
   localparam logic [9:0] C_LW  = 10'h350;   // reg_write, mem_read, mem_to_reg, alu_src, ADD
   localparam logic [9:0] C_ORI = 10'h214;   // reg_write, alu_src, alu_op=OR

`ifdef IMM_ZEXT_EN
   localparam logic [31:0] ORI_IMM_EXP = 32'h0000_8000;
`else
   localparam logic [31:0] ORI_IMM_EXP = 32'hFFFF_8000;
`endif

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;

   always #5 clk_i = ~clk_i;

   id_ex_reg_if #(.DATA_W(32), .CTRL_W(10), .CNT_W(CNT_W)) bus ();

   id_ex_reg #(.DATA_W(32), .CTRL_W(10), .CNT_W(CNT_W)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        hold, flush, valid;
      logic [9:0]  ctrl;
      logic [31:0] pc4, rsd, rtd, imm;
      logic [4:0]  rs, rt, rd;
      logic        zext;
      logic        exp_stall;
      logic        exp_valid;
      logic [9:0]  exp_ctrl;
      logic [1:0]  exp_cnt;
      logic        chk_dp;      // datapath fields must equal this vector's inputs
      logic [31:0] exp_imm;
   } vec_t;

   vec_t vecs [0:21];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic h, input logic f, input logic v, input logic [9:0] c,
      input logic [31:0] pc4, input logic [31:0] rsd, input logic [31:0] rtd,
      input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic z,
      input logic es, input logic ev, input logic [9:0] ec, input logic [1:0] ecnt,
      input logic dp, input logic [31:0] eimm);
      vec_t r;
      r.hold = h; r.flush = f; r.valid = v; r.ctrl = c;
      r.pc4 = pc4; r.rsd = rsd; r.rtd = rtd; r.imm = imm;
      r.rs = rs; r.rt = rt; r.rd = rd; r.zext = z;
      r.exp_stall = es; r.exp_valid = ev; r.exp_ctrl = ec; r.exp_cnt = ecnt;
      r.chk_dp = dp; r.exp_imm = eimm;
      return r;
   endfunction

   task automatic drive(input logic h, input logic f, input logic v, input logic [9:0] c,
                        input logic [31:0] pc4, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic z);
      bus.hold_i = h; bus.flush_i = f; bus.valid_i = v; bus.ctrl_i = c;
      bus.pc4_i = pc4; bus.rs_data_i = rsd; bus.rt_data_i = rtd; bus.imm_i = imm;
      bus.rs_i = rs; bus.rt_i = rt; bus.rd_i = rd; bus.zext_i = z;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".valid"},   32'(bus.valid_o), 32'd0);
      chk({tag, ".ctrl"},    32'(bus.ctrl_o), 32'd0);
      chk({tag, ".pc4"},     bus.pc4_o, 32'd0);
      chk({tag, ".rs_data"}, bus.rs_data_o, 32'd0);
      chk({tag, ".rt_data"}, bus.rt_data_o, 32'd0);
      chk({tag, ".imm"},     bus.imm_o, 32'd0);
      chk({tag, ".rs"},      32'(bus.rs_o), 32'd0);
      chk({tag, ".rt"},      32'(bus.rt_o), 32'd0);
      chk({tag, ".rd"},      32'(bus.rd_o), 32'd0);
      chk({tag, ".cnt"},     32'(bus.bubble_cnt_o), 32'd0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string t;
      t = $sformatf("v%0d", idx);
      @(negedge clk_i);
      drive(v.hold, v.flush, v.valid, v.ctrl, v.pc4, v.rsd, v.rtd, v.imm,
            v.rs, v.rt, v.rd, v.zext);
      #1;
      chk({t, ".stall"}, 32'(bus.stall_o), 32'(v.exp_stall));
      @(posedge clk_i);
      #1;
      chk({t, ".valid"}, 32'(bus.valid_o), 32'(v.exp_valid));
      chk({t, ".ctrl"},  32'(bus.ctrl_o), 32'(v.exp_ctrl));
      chk({t, ".cnt"},   32'(bus.bubble_cnt_o), 32'(v.exp_cnt));
      if (v.chk_dp) begin
         chk({t, ".pc4"},     bus.pc4_o, v.pc4);
         chk({t, ".rs_data"}, bus.rs_data_o, v.rsd);
         chk({t, ".rt_data"}, bus.rt_data_o, v.rtd);
         chk({t, ".imm"},     bus.imm_o, v.exp_imm);
         chk({t, ".rs"},      32'(bus.rs_o), 32'(v.rs));
         chk({t, ".rt"},      32'(bus.rt_o), 32'(v.rt));
         chk({t, ".rd"},      32'(bus.rd_o), 32'(v.rd));
      end
      $display("vec %0d: hold=%0b flush=%0b valid_i=%0b rs=%0d rt=%0d -> valid_o=%0b ctrl_o=%h cnt=%0d",
               idx, v.hold, v.flush, v.valid, v.rs, v.rt, bus.valid_o, bus.ctrl_o, bus.bubble_cnt_o);
   endtask

   initial begin
      // Watchdog: the whole run is a few hundred cycles.
      #20000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //              h f v ctrl   pc4 rsd  rtd imm          rs rt rd z | st v ctrl  cnt dp eimm
      vecs[0]  = mk(0,0,1,C_ADD, 4,  5,   7,  0,           1, 2, 3, 0,  0, 1,C_ADD,0, 1, 0);
      vecs[1]  = mk(0,0,1,C_LW,  8,  100, 0,  4,           1, 8, 0, 0,  0, 1,C_LW, 0, 1, 4);
      vecs[2]  = mk(0,0,1,C_ADD, 12, 11,  22, 0,           8, 2, 9, 0,  1, 0,10'h0,1, 0, 0);
      vecs[3]  = mk(0,0,1,C_ADD, 12, 11,  22, 0,           8, 2, 9, 0,  0, 1,C_ADD,1, 1, 0);
      vecs[4]  = mk(0,0,1,C_LW,  16, 50,  0,  8,           2, 0, 0, 0,  0, 1,C_LW, 1, 1, 8);
      vecs[5]  = mk(0,0,1,C_ADD, 20, 0,   0,  0,           0, 0, 4, 0,  0, 1,C_ADD,1, 1, 0);
      vecs[6]  = mk(0,0,1,C_LW,  24, 200, 0,  12,          3, 5, 0, 0,  0, 1,C_LW, 1, 1, 12);
      vecs[7]  = mk(0,1,1,C_ADD, 28, 33,  44, 0,           2, 5, 6, 0,  0, 0,10'h0,1, 0, 0);
      vecs[8]  = mk(0,0,1,C_LW,  32, 300, 0,  0,           1, 7, 0, 0,  0, 1,C_LW, 1, 1, 0);
      vecs[9]  = mk(1,0,1,C_ADD, 36, 1,   2,  0,           7, 3, 10,0,  1, 1,C_LW, 1, 0, 0);
      vecs[10] = mk(0,0,1,C_ADD, 36, 1,   2,  0,           7, 3, 10,0,  1, 0,10'h0,2, 0, 0);
      vecs[11] = mk(0,0,1,C_ADD, 36, 1,   2,  0,           7, 3, 10,0,  0, 1,C_ADD,2, 1, 0);
      vecs[12] = mk(0,0,1,C_ORI, 40, 9,   0,  32'hFFFF8000,4, 11,0, 1,  0, 1,C_ORI,2, 1, ORI_IMM_EXP);
      vecs[13] = mk(0,0,0,C_ADD, 44, 1,   2,  3,           5, 6, 7, 0,  0, 0,10'h0,2, 1, 3);
      vecs[14] = mk(0,0,1,C_LW,  48, 400, 0,  16,          1, 12,0, 0,  0, 1,C_LW, 2, 1, 16);
      vecs[15] = mk(0,0,0,C_ADD, 52, 1,   2,  0,           12,12,13,0,  0, 0,10'h0,2, 1, 0);
      vecs[16] = mk(0,0,1,C_LW,  56, 500, 0,  20,          1, 12,0, 0,  0, 1,C_LW, 2, 1, 20);
      vecs[17] = mk(0,0,1,C_ADD, 60, 6,   7,  0,           3, 12,14,0,  1, 0,10'h0,3, 0, 0);
      vecs[18] = mk(0,0,1,C_ADD, 60, 6,   7,  0,           3, 12,14,0,  0, 1,C_ADD,3, 1, 0);
      vecs[19] = mk(0,0,1,C_LW,  64, 600, 0,  24,          2, 15,0, 0,  0, 1,C_LW, 3, 1, 24);
      vecs[20] = mk(0,0,1,C_ADD, 68, 8,   9,  0,           15,1, 16,0,  1, 0,10'h0,3, 0, 0);
      vecs[21] = mk(0,0,1,C_ADD, 68, 8,   9,  0,           15,1, 16,0,  0, 1,C_ADD,3, 1, 0);

      // ---- reset with random inputs ----
      rst_i = 1'b0;
      drive(1'b0, 1'(($urandom)), 1'($urandom), 10'($urandom), $urandom, $urandom,
            $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk_all_zero("reset");
      chk("reset.stall", 32'(bus.stall_o), 32'd0);
      $display("reset: outputs checked while rst_i low");
      rst_i = 1'b1;

      // ---- table ----
      for (int i = 0; i < 22; i++) begin
         run_vec(vecs[i], i);
      end

      // ---- hold for 3 cycles with changing inputs ----
      @(negedge clk_i);
      drive(0, 0, 1, C_LW, 72, 700, 0, 28, 1, 13, 0, 0);
      @(posedge clk_i); #1;
      chk("hold.pre.ctrl", 32'(bus.ctrl_o), 32'(C_LW));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         drive(1, 0, 1, C_ADD, 32'(100 + k), 32'(1000 + k), 32'(2000 + k), 32'(k),
               5'(13), 5'(k + 1), 5'(20 + k), 0);
         #1;
         chk($sformatf("hold%0d.stall", k), 32'(bus.stall_o), 32'd1);
         @(posedge clk_i); #1;
         chk($sformatf("hold%0d.valid", k),   32'(bus.valid_o), 32'd1);
         chk($sformatf("hold%0d.ctrl", k),    32'(bus.ctrl_o), 32'(C_LW));
         chk($sformatf("hold%0d.rs_data", k), bus.rs_data_o, 32'd700);
         chk($sformatf("hold%0d.pc4", k),     bus.pc4_o, 32'd72);
         chk($sformatf("hold%0d.rt", k),      32'(bus.rt_o), 32'd13);
         chk($sformatf("hold%0d.cnt", k),     32'(bus.bubble_cnt_o), 32'd3);
         $display("hold cycle %0d: stall_o=%0b ctrl_o=%h rs_data_o=%0d",
                  k, bus.stall_o, bus.ctrl_o, bus.rs_data_o);
      end
      @(negedge clk_i);
      drive(0, 0, 1, C_ADD, 80, 77, 88, 0, 1, 2, 17, 0);
      #1;
      chk("release.stall", 32'(bus.stall_o), 32'd0);
      @(posedge clk_i); #1;
      chk("release.valid",   32'(bus.valid_o), 32'd1);
      chk("release.ctrl",    32'(bus.ctrl_o), 32'(C_ADD));
      chk("release.rs_data", bus.rs_data_o, 32'd77);
      chk("release.rd",      32'(bus.rd_o), 32'd17);
      $display("hold release: valid_o=%0b rs_data_o=%0d", bus.valid_o, bus.rs_data_o);

      // ---- reset asserted mid-stall ----
      @(negedge clk_i);
      drive(0, 0, 1, C_LW, 84, 900, 0, 32, 2, 14, 0, 0);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      drive(0, 0, 1, C_ADD, 88, 3, 4, 0, 14, 1, 18, 0);
      #1;
      chk("rststall.stall_pre", 32'(bus.stall_o), 32'd1);
      #1;
      rst_i = 1'b0;
      #1;
      chk_all_zero("rststall");
      chk("rststall.stall", 32'(bus.stall_o), 32'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
      drive(0, 0, 1, C_ADD, 4, 5, 7, 0, 5, 6, 3, 0);
      @(posedge clk_i); #1;
      chk("postrst.valid",   32'(bus.valid_o), 32'd1);
      chk("postrst.ctrl",    32'(bus.ctrl_o), 32'(C_ADD));
      chk("postrst.rs_data", bus.rs_data_o, 32'd5);
      chk("postrst.rt_data", bus.rt_data_o, 32'd7);
      chk("postrst.cnt",     32'(bus.bubble_cnt_o), 32'd0);
      $display("reset mid-stall: valid_o=%0b cnt=%0d", bus.valid_o, bus.bubble_cnt_o);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register of the pipelined MIPS datapath. It captures the decode-stage outputs (register operands, the 32-bit sign-extended immediate, PC+4, register indices, control bits) and presents them to the EX stage one cycle later. It also performs load-use hazard detection, inserting bubbles and stalling upstream, and applies branch flushes and external hold.

## Interface
- Parameters:
- DATA_W, 32, operand/immediate/PC width
- CTRL_W, 10, packed control bundle width (bit layout in id_ex_pkg)
- CNT_W, 16, bubble counter width
- Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- hold_i  in  1  freeze request from downstream (memory busy)
- flush_i  in  1  branch-taken flush from EX/MEM
- valid_i  in  1  ID instruction is valid
- ctrl_i  in  CTRL_W  decode control bundle (reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src, reg_dst, alu_op[2:0])
- pc4_i, rs_data_i, rt_data_i, imm_i  in  DATA_W  PC+4, register file reads, sign-extended immediate
- rs_i, rt_i, rd_i  in  5  register indices
- zext_i  in  1  logical-immediate select (used only with IMM_ZEXT_EN)
- valid_o, ctrl_o, pc4_o, rs_data_o, rt_data_o, imm_o, rs_o, rt_o, rd_o  out  (as inputs)  registered EX-stage copies
- stall_o  out  1  freeze PC and IF/ID this cycle
- bubble_cnt_o  out  CNT_W  saturating count of inserted bubbles

## Operation
- Reset (rst_i low, immediate): every registered output, including valid_o, ctrl_o and bubble_cnt_o, is 0.
- load_use = valid_o & ctrl_o.mem_read & (rt_o != 0) & valid_i & ((rt_o == rs_i) | (rt_o == rt_i)). Combinational from current EX contents and ID inputs.
- stall_o = hold_i | (load_use & ~flush_i).
- Per-edge priority:
- hold_i=1: all registers keep their value. This includes valid_o and bubble_cnt_o.
- else flush_i=1: valid_o<=0 and ctrl_o<=0; the datapath fields are don't-care and are loaded normally.
- else load_use: bubble. valid_o<=0, ctrl_o<=0, bubble_cnt_o increments and saturates at all-ones.
- else: load all fields from the inputs. valid_o<=valid_i. ctrl_o<=valid_i ? ctrl_i : 0.
- A bubble or invalid entry never carries nonzero control bits, so EX, MEM and WB perform no architectural writes for it.
- Register index 0 never triggers a hazard.

## Timing
- Latency: 1 cycle from ID inputs to EX outputs.
- Load-use example:
- Cycle N: lw is in EX and the dependent instruction is in ID, so stall_o=1.
- Edge N+1: a bubble enters EX, and PC and IF/ID hold.
- Cycle N+1: load_use=0 because the EX entry is invalid. The dependent instruction loads at edge N+2.
- Exactly one bubble is inserted per load-use pair.
- Flush together with load_use: the flush wins. stall_o=0 and the counter does not increment.
- Hold together with load_use: stall_o=1 and there is no bubble and no increment. The hazard re-evaluates after hold drops.
- Reset asserted mid-stall clears all state. The first edge after deassertion is a normal load.

## Configuration
- IMM_ZEXT_EN defined: zext_i is registered alongside the control bits. When it is set, imm_o[31:16] is forced to 0 at load time, giving zero-extension for andi/ori/xori. A bubble or flush clears the registered zext.
- IMM_ZEXT_EN undefined: zext_i is ignored and imm_o is imm_i registered unchanged.

## Structure
- Package id_ex_pkg holds:
- CTRL_W and the bit index localparams for each control field (CTRL_REG_WRITE … CTRL_ALU_OP_LSB).
- The ALU_OP encodings shared with the decoder and ALU control.
- Sub-module hazard_detect: purely combinational. It takes valid_o, mem_read, rt_o, valid_i, rs_i and rt_i, and outputs load_use.

## Test plan
- Reset: hold rst_i low with random inputs. All outputs must be 0. Release, then apply add $3,$1,$2 (rs_data=5, rt_data=7). Next cycle: valid_o=1, rs_data_o=5, rt_data_o=7.
- Load-use: EX holds lw $8 (mem_read=1, rt_o=8) and ID presents add rs=8.
- stall_o=1 for exactly one cycle.
- Next cycle: valid_o=0, ctrl_o=0, bubble_cnt_o=1.
- The following cycle: add is in EX.
- Zero register: EX holds lw with rt_o=0 and ID rs=0. Required: stall_o=0 and no bubble.
- Flush priority: flush_i=1 while load_use=1. Required: stall_o=0, ctrl_o=0 next cycle, bubble_cnt_o unchanged.
- Hold: hold_i=1 for 3 cycles with changing inputs. Outputs stay frozen and stall_o=1. Release: the inputs present at release load.
- IMM_ZEXT_EN: imm_i=32'hFFFF8000 with zext_i=1. Built with the macro, imm_o=32'h00008000; built without it, imm_o=32'hFFFF8000.
